// File: rtl/hft_pkg.sv
// Shared constants, FSM state encoding and tick-word field helpers for the order path.
package hft_pkg;

  localparam int PRICE_W    = 14;
  localparam int ID_W       = 2;
  localparam int NUM_STOCKS = 4;
  localparam int TICK_W     = ID_W + PRICE_W;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_COOLDOWN = 2'd2
  } state_e;

  function automatic logic [ID_W-1:0] tick_id(input logic [TICK_W-1:0] tick);
    return tick[TICK_W-1:PRICE_W];
  endfunction

  function automatic logic [PRICE_W-1:0] tick_price(input logic [TICK_W-1:0] tick);
    return tick[PRICE_W-1:0];
  endfunction

endpackage

// File: rtl/order_manager_if.sv
// Market tick input plus order valid/ready channel between strategy and exchange.
interface order_manager_if;
  import hft_pkg::*;

  logic                tick_valid;
  logic [TICK_W-1:0]   tick_data;
  logic                buy_sig;
  logic                sell_sig;
  logic                order_valid;
  logic                order_ready;
  logic                order_side;
  logic [ID_W-1:0]     order_stock;
  logic [PRICE_W-1:0]  order_price;

  // master: the order manager, which consumes ticks and issues orders
  modport master (
    input  tick_valid, tick_data, buy_sig, sell_sig, order_ready,
    output order_valid, order_side, order_stock, order_price
  );

  modport slave (
    output tick_valid, tick_data, buy_sig, sell_sig, order_ready,
    input  order_valid, order_side, order_stock, order_price
  );

endinterface

// File: rtl/sat_add_signed.sv
// Signed adder of width W that clamps to the most positive/negative value on overflow.
module sat_add_signed #(
  parameter int W = 16
) (
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_i,
  output logic signed [W-1:0] sum_o
);

  logic signed [W:0] full_s;

  // Add one bit wider, then clamp when the two top bits disagree
  always_comb begin
    full_s = $signed({a_i[W-1], a_i}) + $signed({b_i[W-1], b_i});
    if (full_s[W] != full_s[W-1]) begin
      sum_o = full_s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      sum_o = full_s[W-1:0];
    end
  end

endmodule

// File: rtl/order_manager.sv
// Converts voted buy/sell ticks into single-lot orders, tracking per-stock position,
// entry prices, saturating realized P&L and a saturating count of dropped opportunities.
module order_manager
  import hft_pkg::*;
#(
  parameter int COOLDOWN = 4,
  parameter int TIMEOUT  = 16,
  parameter int PNL_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  order_manager_if.master         bus,
  output logic [NUM_STOCKS-1:0]   position,
  output logic signed [PNL_W-1:0] realized_pnl,
  output logic                    busy,
  output logic [7:0]              drop_count
);

  localparam int DIFF_W = PRICE_W + 1;

  state_e                    state_q;
  logic [7:0]                cnt_q;
  logic                      valid_q;
  logic                      side_q;
  logic [ID_W-1:0]           stock_q;
  logic [PRICE_W-1:0]        price_q;
  logic [NUM_STOCKS-1:0]     pos_q;
  logic [PRICE_W-1:0]        entry_q [NUM_STOCKS];
  logic signed [PNL_W-1:0]   pnl_q;
  logic [7:0]                drop_q;
  logic [7:0]                drop_d;

  logic [ID_W-1:0]           tick_id_s;
  logic [PRICE_W-1:0]        tick_price_s;
  logic                      qualify_s;
  logic                      timeout_s;
  logic [1:0]                drop_inc_s;
  logic [8:0]                drop_sum_s;
  logic signed [DIFF_W-1:0]  diff_s;
  logic signed [PNL_W-1:0]   diff_ext_s;
  logic signed [PNL_W-1:0]   pnl_sum_s;

  assign tick_id_s    = tick_id(bus.tick_data);
  assign tick_price_s = tick_price(bus.tick_data);

  // Opportunity test against the position as it stands before this cycle's fill
  assign qualify_s = bus.tick_valid & enable &
                     ((bus.buy_sig & ~bus.sell_sig & ~pos_q[tick_id_s]) |
                      (bus.sell_sig & ~bus.buy_sig & pos_q[tick_id_s]));

  assign timeout_s = (state_q == S_ISSUE) & ~bus.order_ready & (cnt_q == 8'(TIMEOUT - 1));

  assign diff_s     = $signed({1'b0, price_q}) - $signed({1'b0, entry_q[stock_q]});
  assign diff_ext_s = {{(PNL_W-DIFF_W){diff_s[DIFF_W-1]}}, diff_s};

  sat_add_signed #(.W(PNL_W)) u_pnl_add (
    .a_i   (pnl_q),
    .b_i   (diff_ext_s),
    .sum_o (pnl_sum_s)
  );

  // A busy-state tick drop and a timeout can coincide, so the increment may be two
  always_comb begin
    drop_inc_s = {1'b0, (state_q != S_IDLE) & qualify_s} + {1'b0, timeout_s};
    drop_sum_s = {1'b0, drop_q} + {7'd0, drop_inc_s};
    if (drop_sum_s[8]) begin
      drop_d = 8'hFF;
    end else begin
      drop_d = drop_sum_s[7:0];
    end
  end

  // Order FSM with position, entry price and P&L bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      valid_q <= 1'b0;
      side_q  <= 1'b0;
      stock_q <= '0;
      price_q <= '0;
      pos_q   <= '0;
      pnl_q   <= '0;
      drop_q  <= 8'd0;
      for (int i = 0; i < NUM_STOCKS; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      drop_q <= drop_d;
      case (state_q)
        S_IDLE: begin
          if (qualify_s) begin
            side_q  <= bus.buy_sig;
            stock_q <= tick_id_s;
            price_q <= tick_price_s;
            valid_q <= 1'b1;
            cnt_q   <= 8'd0;
            state_q <= S_ISSUE;
          end else begin
            valid_q <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (bus.order_ready) begin
            valid_q <= 1'b0;
            cnt_q   <= 8'd0;
            if (side_q) begin
              pos_q[stock_q]   <= 1'b1;
              entry_q[stock_q] <= price_q;
            end else begin
              pos_q[stock_q] <= 1'b0;
              pnl_q          <= pnl_sum_s;
            end
            state_q <= (COOLDOWN == 0) ? S_IDLE : S_COOLDOWN;
          end else if (timeout_s) begin
            valid_q <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_COOLDOWN: begin
          if (cnt_q == 8'(COOLDOWN - 1)) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.order_valid = valid_q;
  assign bus.order_side  = side_q;
  assign bus.order_stock = stock_q;
  assign bus.order_price = price_q;
  assign position        = pos_q;
  assign realized_pnl    = pnl_q;
  assign busy            = (state_q != S_IDLE);
  assign drop_count      = drop_q;

endmodule
